// File: rtl/control_multiciclo_pkg.sv
// -----------------------------------------------------------------------------
// control_multiciclo_pkg
// Shared definitions for the multicycle MIPS control unit: opcodes, state
// encodings, ALU operation codes, mux select codes and the bundled control
// word that the output decoder produces.
// -----------------------------------------------------------------------------
package control_multiciclo_pkg;

  // Opcodes (IR[31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // State encoding is visible on the Estado debug port, so values are fixed
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } estado_t;

  // ALUOP codes
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_FUNCT = 3'b010;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_CUATRO  = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSource selects
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Complete control word driven towards the datapath
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NULO = '0;

  // True for every opcode the controller knows how to sequence
  function automatic logic op_soportado(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/control_multiciclo_if.sv
// -----------------------------------------------------------------------------
// control_multiciclo_if
// Bundle between the multicycle controller and the shared datapath.
//   master : the controller (drives enables/selects/debug, reads Op/MemReady)
//   slave  : the datapath side (drives Op and MemReady)
// -----------------------------------------------------------------------------
interface control_multiciclo_if;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUOP;
  logic [1:0] PCSource;
  logic       Illegal;
  logic [3:0] Estado;

  modport master (
    input  Op, MemReady,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource, Illegal, Estado
  );

  modport slave (
    output Op, MemReady,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
           RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource, Illegal, Estado
  );
endinterface

// File: rtl/control_multiciclo_salidas.sv
// -----------------------------------------------------------------------------
// control_multiciclo_salidas
// Purely combinational Moore decoder from the current state to the control
// word. MemReady only qualifies the FETCH enables, Op only feeds Illegal in
// DECODE. While i_rst is high the whole control word is forced to zero.
// Ports:
//   i_estado     current FSM state
//   i_rst        synchronous reset level (gates every output)
//   i_op         opcode, used only to flag unsupported instructions
//   i_mem_ready  memory handshake, qualifies PCWrite/IRWrite in FETCH
//   o_ctrl       control word
// -----------------------------------------------------------------------------
module control_multiciclo_salidas
  import control_multiciclo_pkg::*;
(
  input  estado_t    i_estado,
  input  logic       i_rst,
  input  logic [5:0] i_op,
  input  logic       i_mem_ready,
  output ctrl_t      o_ctrl
);

  ctrl_t w_ctrl;

  // State-to-control-word decode; unlisted fields stay zero
  always_comb begin
    w_ctrl = CTRL_NULO;
    case (i_estado)
      S_FETCH: begin
        w_ctrl.mem_read  = 1'b1;
        w_ctrl.iord      = 1'b0;
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_CUATRO;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.pc_source = PCSRC_ALU;
        // PC+4 and IR load only in the completing cycle: one increment per fetch
        w_ctrl.ir_write  = i_mem_ready;
        w_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut
        w_ctrl.alu_src_a = 1'b0;
        w_ctrl.alu_src_b = SRCB_IMM_SH2;
        w_ctrl.alu_op    = ALUOP_ADD;
        w_ctrl.illegal   = ~op_soportado(i_op);
      end
      S_MEMADR, S_ADDIEX: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_IMM;
        w_ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        w_ctrl.mem_read = 1'b1;
        w_ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
      end
      S_MEMWR: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_src_b = SRCB_B;
        w_ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b1;
        w_ctrl.mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        w_ctrl.alu_src_a     = 1'b1;
        w_ctrl.alu_src_b     = SRCB_B;
        w_ctrl.alu_op        = ALUOP_SUB;
        w_ctrl.pc_write_cond = 1'b1;
        w_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        w_ctrl.pc_write  = 1'b1;
        w_ctrl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        w_ctrl.reg_write  = 1'b1;
        w_ctrl.reg_dst    = 1'b0;
        w_ctrl.mem_to_reg = 1'b0;
      end
      default: w_ctrl = CTRL_NULO;
    endcase
  end

  // Reset masks every strobe immediately, so an aborted instruction never writes
  assign o_ctrl = i_rst ? CTRL_NULO : w_ctrl;

endmodule

// File: rtl/control_multiciclo.sv
// -----------------------------------------------------------------------------
// control_multiciclo
// Multicycle MIPS control FSM. Steps each instruction through fetch, decode,
// execute, memory and write-back, stalling FETCH/MEMRD/MEMWR until MemReady.
// Ports:
//   i_clk   system clock, rising edge
//   i_rst   synchronous active-high reset (state -> FETCH, outputs forced 0)
//   io_bus  controller side of control_multiciclo_if (Op, MemReady in;
//           enables, selects, Illegal and Estado out)
// -----------------------------------------------------------------------------
module control_multiciclo
  import control_multiciclo_pkg::*;
(
  input  logic                        i_clk,
  input  logic                        i_rst,
  control_multiciclo_if.master        io_bus
);

  estado_t r_estado;
  ctrl_t   w_ctrl;

  // State register and next-state logic
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_estado <= S_FETCH;
    end else begin
      case (r_estado)
        S_FETCH:  r_estado <= io_bus.MemReady ? S_DECODE : S_FETCH;
        S_DECODE: begin
          case (io_bus.Op)
            OP_RTYPE:     r_estado <= S_EXEC;
            OP_LW, OP_SW: r_estado <= S_MEMADR;
            OP_BEQ:       r_estado <= S_BRANCH;
            OP_J:         r_estado <= S_JUMP;
            OP_ADDI:      r_estado <= S_ADDIEX;
            default:      r_estado <= S_FETCH;
          endcase
        end
        // Op is re-read here to split the shared address computation
        S_MEMADR: r_estado <= (io_bus.Op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  r_estado <= io_bus.MemReady ? S_MEMWB : S_MEMRD;
        S_MEMWB:  r_estado <= S_FETCH;
        S_MEMWR:  r_estado <= io_bus.MemReady ? S_FETCH : S_MEMWR;
        S_EXEC:   r_estado <= S_RWB;
        S_RWB:    r_estado <= S_FETCH;
        S_BRANCH: r_estado <= S_FETCH;
        S_JUMP:   r_estado <= S_FETCH;
        S_ADDIEX: r_estado <= S_ADDIWB;
        S_ADDIWB: r_estado <= S_FETCH;
        default:  r_estado <= S_FETCH;
      endcase
    end
  end

  control_multiciclo_salidas u_salidas (
    .i_estado    (r_estado),
    .i_rst       (i_rst),
    .i_op        (io_bus.Op),
    .i_mem_ready (io_bus.MemReady),
    .o_ctrl      (w_ctrl)
  );

  assign io_bus.PCWrite     = w_ctrl.pc_write;
  assign io_bus.PCWriteCond = w_ctrl.pc_write_cond;
  assign io_bus.IorD        = w_ctrl.iord;
  assign io_bus.MemRead     = w_ctrl.mem_read;
  assign io_bus.MemWrite    = w_ctrl.mem_write;
  assign io_bus.IRWrite     = w_ctrl.ir_write;
  assign io_bus.MemToReg    = w_ctrl.mem_to_reg;
  assign io_bus.RegDst      = w_ctrl.reg_dst;
  assign io_bus.RegWrite    = w_ctrl.reg_write;
  assign io_bus.ALUSrcA     = w_ctrl.alu_src_a;
  assign io_bus.ALUSrcB     = w_ctrl.alu_src_b;
  assign io_bus.ALUOP       = w_ctrl.alu_op;
  assign io_bus.PCSource    = w_ctrl.pc_source;
  assign io_bus.Illegal     = w_ctrl.illegal;
  // Debug view is the raw state register, not gated by reset
  assign io_bus.Estado      = r_estado;

endmodule

// File: tb/tb_control_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_control_multiciclo
// Directed vector table for the listed corner cases, then a random instruction
// stream checked against an instruction-path reference model.
// -----------------------------------------------------------------------------
module tb_control_multiciclo;

  logic clk;
  logic rst;

  control_multiciclo_if bus ();

  control_multiciclo dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout:
  // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemToReg,RegDst,
  //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOP[2:0],PCSource[1:0],Illegal}
  logic [17:0] dut_outs;
  assign dut_outs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                     bus.MemWrite, bus.IRWrite, bus.MemToReg, bus.RegDst,
                     bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOP,
                     bus.PCSource, bus.Illegal};

  //                                        pcw  pcwc iord mrd  mwr  irw  m2r  rdst rw   srca srcb   aluop   pcsrc  ill
  localparam logic [17:0] O_ZERO       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_FETCH_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_FETCH_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_DECODE     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_ILLEGAL    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,3'b000,2'b00,1'b1};
  localparam logic [17:0] O_ADDR_IMM   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_MEMRD      = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_MEMWB      = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_MEMWR      = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_EXEC       = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b010,2'b00,1'b0};
  localparam logic [17:0] O_RWB        = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};
  localparam logic [17:0] O_BRANCH     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,3'b001,2'b01,1'b0};
  localparam logic [17:0] O_JUMP       = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,3'b000,2'b10,1'b0};
  localparam logic [17:0] O_ADDIWB     = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,3'b000,2'b00,1'b0};

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  est;
    logic [17:0] outs;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  int n_tests;
  int n_fail;

  function automatic logic legal_op(input logic [5:0] op);
    return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
           (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
  endfunction

  // Expected control word for a state number, straight from the state table
  function automatic logic [17:0] exp_outs(input logic [3:0] st, input logic [5:0] op,
                                           input logic mr, input logic r);
    logic [17:0] v;
    if (r) v = O_ZERO;
    else begin
      case (st)
        4'd0:    v = mr ? O_FETCH_RDY : O_FETCH_WAIT;
        4'd1:    v = legal_op(op) ? O_DECODE : O_ILLEGAL;
        4'd2:    v = O_ADDR_IMM;
        4'd3:    v = O_MEMRD;
        4'd4:    v = O_MEMWB;
        4'd5:    v = O_MEMWR;
        4'd6:    v = O_EXEC;
        4'd7:    v = O_RWB;
        4'd8:    v = O_BRANCH;
        4'd9:    v = O_JUMP;
        4'd10:   v = O_ADDR_IMM;
        4'd11:   v = O_ADDIWB;
        default: v = O_ZERO;
      endcase
    end
    return v;
  endfunction

  // Drive one cycle's inputs at the falling edge and check outputs 1 ns later
  task automatic step_check(input logic r, input logic [5:0] op, input logic mr,
                            input logic [3:0] est, input logic [17:0] outs,
                            input string tag, input int idx);
    @(negedge clk);
    rst          = r;
    bus.Op       = op;
    bus.MemReady = mr;
    #1;
    n_tests++;
    if (bus.Estado !== est) begin
      n_fail++;
      $display("FAIL %s[%0d] Estado: got %0d expected %0d", tag, idx, bus.Estado, est);
    end
    n_tests++;
    if (dut_outs !== outs) begin
      n_fail++;
      $display("FAIL %s[%0d] outputs (Estado %0d): got %b expected %b", tag, idx, est, dut_outs, outs);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [5:0] op, input logic mr,
                              input logic [3:0] est, input logic [17:0] outs);
    vec_t v;
    v.rst = r; v.op = op; v.mr = mr; v.est = est; v.outs = outs;
    return v;
  endfunction

  // Reference model state: path of state numbers for the current instruction
  logic [23:0] path_w;
  int          plen;
  int          pidx;
  logic [5:0]  iop;

  task automatic new_instr();
    int k;
    k = $urandom_range(0, 6);
    case (k)
      0: begin iop = 6'b000000; path_w = {12'd0, 4'd7, 4'd6, 4'd1, 4'd0};   plen = 4; end
      1: begin iop = 6'b100011; path_w = {8'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0}; plen = 5; end
      2: begin iop = 6'b101011; path_w = {12'd0, 4'd5, 4'd2, 4'd1, 4'd0};   plen = 4; end
      3: begin iop = 6'b000100; path_w = {16'd0, 4'd8, 4'd1, 4'd0};         plen = 3; end
      4: begin iop = 6'b000010; path_w = {16'd0, 4'd9, 4'd1, 4'd0};         plen = 3; end
      5: begin iop = 6'b001000; path_w = {12'd0, 4'd11, 4'd10, 4'd1, 4'd0}; plen = 4; end
      default: begin
        iop = 6'($urandom_range(0, 63));
        while (legal_op(iop)) iop = 6'($urandom_range(0, 63));
        path_w = {20'd0, 4'd1, 4'd0};
        plen = 2;
      end
    endcase
    pidx = 0;
  endtask

  initial begin
    logic [3:0] st;
    logic [5:0] op;
    logic       mr;
    logic       r;

    n_tests = 0;
    n_fail  = 0;
    rst          = 1'b1;
    bus.Op       = 6'b000000;
    bus.MemReady = 1'b0;
    @(posedge clk);

    // rst, op, MemReady, expected Estado, expected outputs
    vecs[0]  = mk(1'b1, 6'h00, 1'b1, 4'd0,  O_ZERO);       // second reset cycle
    vecs[1]  = mk(1'b0, 6'h3f, 1'b1, 4'd0,  O_FETCH_RDY);  // first cycle after release
    vecs[2]  = mk(1'b0, 6'h23, 1'b1, 4'd1,  O_DECODE);     // lw
    vecs[3]  = mk(1'b0, 6'h23, 1'b1, 4'd2,  O_ADDR_IMM);
    vecs[4]  = mk(1'b0, 6'h23, 1'b1, 4'd3,  O_MEMRD);
    vecs[5]  = mk(1'b0, 6'h23, 1'b1, 4'd4,  O_MEMWB);
    vecs[6]  = mk(1'b0, 6'h2b, 1'b1, 4'd0,  O_FETCH_RDY);  // sw with two wait states
    vecs[7]  = mk(1'b0, 6'h2b, 1'b1, 4'd1,  O_DECODE);
    vecs[8]  = mk(1'b0, 6'h2b, 1'b1, 4'd2,  O_ADDR_IMM);
    vecs[9]  = mk(1'b0, 6'h2b, 1'b0, 4'd5,  O_MEMWR);
    vecs[10] = mk(1'b0, 6'h2b, 1'b0, 4'd5,  O_MEMWR);
    vecs[11] = mk(1'b0, 6'h2b, 1'b1, 4'd5,  O_MEMWR);
    vecs[12] = mk(1'b0, 6'h04, 1'b0, 4'd0,  O_FETCH_WAIT); // beq, fetch wait
    vecs[13] = mk(1'b0, 6'h04, 1'b1, 4'd0,  O_FETCH_RDY);
    vecs[14] = mk(1'b0, 6'h04, 1'b1, 4'd1,  O_DECODE);
    vecs[15] = mk(1'b0, 6'h04, 1'b1, 4'd8,  O_BRANCH);
    vecs[16] = mk(1'b0, 6'h02, 1'b1, 4'd0,  O_FETCH_RDY);  // j
    vecs[17] = mk(1'b0, 6'h02, 1'b1, 4'd1,  O_DECODE);
    vecs[18] = mk(1'b0, 6'h02, 1'b1, 4'd9,  O_JUMP);
    vecs[19] = mk(1'b0, 6'h3f, 1'b1, 4'd0,  O_FETCH_RDY);  // unsupported opcode
    vecs[20] = mk(1'b0, 6'h3f, 1'b1, 4'd1,  O_ILLEGAL);
    vecs[21] = mk(1'b0, 6'h08, 1'b1, 4'd0,  O_FETCH_RDY);  // addi
    vecs[22] = mk(1'b0, 6'h08, 1'b1, 4'd1,  O_DECODE);
    vecs[23] = mk(1'b0, 6'h08, 1'b1, 4'd10, O_ADDR_IMM);
    vecs[24] = mk(1'b0, 6'h08, 1'b1, 4'd11, O_ADDIWB);
    vecs[25] = mk(1'b0, 6'h00, 1'b1, 4'd0,  O_FETCH_RDY);  // R-type, reset in RWB
    vecs[26] = mk(1'b0, 6'h00, 1'b1, 4'd1,  O_DECODE);
    vecs[27] = mk(1'b0, 6'h00, 1'b1, 4'd6,  O_EXEC);
    vecs[28] = mk(1'b1, 6'h00, 1'b1, 4'd7,  O_ZERO);
    vecs[29] = mk(1'b0, 6'h3f, 1'b1, 4'd0,  O_FETCH_RDY);
    vecs[30] = mk(1'b1, 6'h3f, 1'b1, 4'd1,  O_ZERO);       // reset in DECODE masks Illegal

    for (int i = 0; i < NVEC; i++) begin
      step_check(vecs[i].rst, vecs[i].op, vecs[i].mr, vecs[i].est, vecs[i].outs, "vec", i);
    end

    // Random instruction stream with wait states, garbage Op and random resets
    new_instr();
    for (int c = 0; c < 3000; c++) begin
      st = path_w[pidx*4 +: 4];
      r  = ($urandom_range(0, 99) < 3);
      mr = ($urandom_range(0, 99) < 70);
      if (st == 4'd1 || st == 4'd2) op = iop;
      else                          op = 6'($urandom_range(0, 63));
      step_check(r, op, mr, st, exp_outs(st, op, mr, r), "rnd", c);
      if (r) new_instr();
      else if ((st == 4'd0 || st == 4'd3 || st == 4'd5) && !mr) pidx = pidx;
      else begin
        pidx++;
        if (pidx == plen) new_instr();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multicycle control FSM that sequences the shared MIPS datapath (single memory, one ALU, register file, PC) in place of the single-cycle UC decoder. It takes the opcode from the instruction register and produces per-state enables and mux selects, stepping each instruction through fetch, decode, execute, memory and write-back. Fetch and data-memory states wait on a memory-ready handshake, so the same controller works with zero-wait and multi-wait-state memories.

## Interface
- No parameters; all widths are fixed by the MIPS-32 datapath.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Op  in  6  opcode, IR[31:26], valid from DECODE onward.
- MemReady  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ZF (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemToReg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- RegDst  out  1  write register: 1 = IR[15:11], 0 = IR[20:16].
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- ALUOP  out  3  000 = add, 001 = sub, 010 = decode funct via ALUControl.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address.
- Illegal  out  1  one-cycle pulse on an unsupported opcode.
- Estado  out  4  current state, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11.
- Outputs are Moore, decoded from the state register. Any output not listed for a state is 0.
- FETCH
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=000, PCSource=00.
  - IRWrite=PCWrite=MemReady.
  - Go to DECODE when MemReady=1; otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=000 (branch target into ALUOut). Dispatch on Op:
  - 000000 → EXEC
  - 100011 (lw) and 101011 (sw) → MEMADR
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - anything else → Illegal=1 this cycle, then FETCH.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOP=000. Go to MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Then FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold until MemReady=1, then go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOP=010. Then RWB.
- RWB: RegWrite=1, RegDst=1, MemToReg=0. Then FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=001, PCWriteCond=1, PCSource=01. Then FETCH.
- JUMP: PCWrite=1, PCSource=10. Then FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOP=000. Then ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemToReg=0. Then FETCH.
- Op is sampled only in DECODE and MEMADR; its value in other states is ignored.

## Timing
- Reset
  - RST=1 at a rising edge sets the state to FETCH.
  - While RST=1, every output is forced to 0 combinationally, including strobes, selects, Illegal and the FETCH enables. Estado still shows the state register, which is 0 after the reset edge.
  - Reset asserted mid-instruction aborts it. No write strobe is issued in the cycle RST is high, even in MEMWR or RWB.
- Cycles per instruction with MemReady tied to 1:
  - beq, j: 3
  - R-type, sw, addi: 4
  - lw: 5
- Each wait cycle (MemReady=0) in FETCH, MEMRD or MEMWR adds exactly one cycle. The strobes stay asserted and the address select stays stable while waiting.
- PCWrite and IRWrite in FETCH are high only in the cycle MemReady=1, so the PC increments exactly once per instruction.
- MemRead and MemWrite are never high in the same cycle.
- Illegal is high for exactly one cycle (DECODE), and only when RST=0.

## Structure
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - the 4-bit state encodings;
  - ALUOP codes;
  - ALUSrcB and PCSource select codes.
- Sub-module control_multiciclo_salidas: a purely combinational state-to-outputs decoder, which also applies the RST gating.
- The top level holds the state register and the next-state logic.

## Test plan
- RST=1 for 2 cycles, then release → all outputs 0 during reset; first cycle after release Estado=0, MemRead=1, PCWrite=1, IRWrite=1 (MemReady=1).
- Op=100011, MemReady=1 → Estado sequence 0,1,2,3,4,0; RegWrite=1 with MemToReg=1 only in state 4; 5 cycles total.
- Op=101011, MemReady=0 for 2 cycles in MEMWR → MemWrite high for 3 cycles with IorD=1; RegWrite never 1; back to FETCH.
- Op=000100, then Op=000010 → BRANCH: PCWriteCond=1, ALUOP=001, PCSource=01; JUMP: PCWrite=1, PCSource=10; each instruction takes 3 cycles.
- Op=111111 → Illegal=1 for one cycle in DECODE, no RegWrite/MemWrite, next state FETCH.
- RST asserted while in RWB with Op=000000 → RegWrite=0 that cycle, Estado=0 after the edge.
